// File: rtl/exec_arbiter.sv
// Two-port arbiter sharing one exec_unit, with results queued in an id-tagged output FIFO.
// Define EXEC_ARB_ROUND_ROBIN_EN for round-robin conflict resolution; otherwise port 0 has fixed priority.

package exec_pkg;
    typedef logic [31:0] arch_reg;

    typedef enum logic {
        OP1_SEL_REG = 1'b0,
        OP1_SEL_PC  = 1'b1
    } op1_sel_e;

    typedef enum logic {
        OP2_SEL_REG = 1'b0,
        OP2_SEL_IMM = 1'b1
    } op2_sel_e;

    typedef enum logic [3:0] {
        EXEC_OP_ADD  = 4'd0,
        EXEC_OP_SUB  = 4'd1,
        EXEC_OP_AND  = 4'd2,
        EXEC_OP_OR   = 4'd3,
        EXEC_OP_XOR  = 4'd4,
        EXEC_OP_SLL  = 4'd5,
        EXEC_OP_SRL  = 4'd6,
        EXEC_OP_SRA  = 4'd7,
        EXEC_OP_SLT  = 4'd8,
        EXEC_OP_SLTU = 4'd9
    } exec_op_e;

    typedef struct packed {
        op1_sel_e op1_sel;
        op2_sel_e op2_sel;
        exec_op_e exec_op;
    } exec_unit_params;
endpackage

module exec_unit
    import exec_pkg::*;
(
    input  arch_reg         i_pc,
    input  arch_reg         i_rs1,
    input  arch_reg         i_rs2,
    input  arch_reg         i_imm,
    input  exec_unit_params i_params,
    output arch_reg         o_result
);
    arch_reg w_op1;
    arch_reg w_op2;

    // Operand selection and ALU; encodings outside the table fall back to ADD.
    always_comb begin
        w_op1 = (i_params.op1_sel == OP1_SEL_PC)  ? i_pc  : i_rs1;
        w_op2 = (i_params.op2_sel == OP2_SEL_IMM) ? i_imm : i_rs2;
        case (i_params.exec_op)
            EXEC_OP_ADD:  o_result = w_op1 + w_op2;
            EXEC_OP_SUB:  o_result = w_op1 - w_op2;
            EXEC_OP_AND:  o_result = w_op1 & w_op2;
            EXEC_OP_OR:   o_result = w_op1 | w_op2;
            EXEC_OP_XOR:  o_result = w_op1 ^ w_op2;
            EXEC_OP_SLL:  o_result = w_op1 << w_op2[4:0];
            EXEC_OP_SRL:  o_result = w_op1 >> w_op2[4:0];
            EXEC_OP_SRA:  o_result = arch_reg'($signed(w_op1) >>> w_op2[4:0]);
            EXEC_OP_SLT:  o_result = {31'd0, ($signed(w_op1) < $signed(w_op2))};
            EXEC_OP_SLTU: o_result = {31'd0, (w_op1 < w_op2)};
            default:      o_result = w_op1 + w_op2;
        endcase
    end
endmodule

module exec_arbiter
    import exec_pkg::*;
#(
    parameter int OUT_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  arch_reg         req0_pc,
    input  arch_reg         req0_rs1,
    input  arch_reg         req0_rs2,
    input  arch_reg         req0_imm,
    input  exec_unit_params req0_params,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  arch_reg         req1_pc,
    input  arch_reg         req1_rs1,
    input  arch_reg         req1_rs2,
    input  arch_reg         req1_imm,
    input  exec_unit_params req1_params,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output arch_reg         rsp_data,
    output logic            busy
);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(OUT_DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);

    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [32:0]   r_mem [OUT_DEPTH];

    logic            w_rsp_valid;
    logic            w_pop;
    logic            w_open;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_push;
    arch_reg         w_pc;
    arch_reg         w_rs1;
    arch_reg         w_rs2;
    arch_reg         w_imm;
    exec_unit_params w_params;
    arch_reg         w_result;

`ifdef EXEC_ARB_ROUND_ROBIN_EN
    logic r_last_grant;
`endif

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_rsp_valid = reset_n & (r_count != {CW{1'b0}});
    assign w_pop       = w_rsp_valid & rsp_ready;
    assign w_open      = reset_n & ((r_count < DEPTH_C) | w_pop);

    // Grant selection.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_open && req0_valid && req1_valid) begin
`ifdef EXEC_ARB_ROUND_ROBIN_EN
            w_gnt0 = r_last_grant;
            w_gnt1 = ~r_last_grant;
`else
            w_gnt0 = 1'b1;
`endif
        end else if (w_open) begin
            w_gnt0 = req0_valid;
            w_gnt1 = req1_valid;
        end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign w_push     = w_gnt0 | w_gnt1;

    // Operand mux; port 0 is presented whenever port 1 is not granted.
    always_comb begin
        if (w_gnt1) begin
            w_pc     = req1_pc;
            w_rs1    = req1_rs1;
            w_rs2    = req1_rs2;
            w_imm    = req1_imm;
            w_params = req1_params;
        end else begin
            w_pc     = req0_pc;
            w_rs1    = req0_rs1;
            w_rs2    = req0_rs2;
            w_imm    = req0_imm;
            w_params = req0_params;
        end
    end

    exec_unit u_exec_unit (
        .i_pc     (w_pc),
        .i_rs1    (w_rs1),
        .i_rs2    (w_rs2),
        .i_imm    (w_imm),
        .i_params (w_params),
        .o_result (w_result)
    );

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count  <= {CW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_mem[i] <= 33'd0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_gnt1, w_result};
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef EXEC_ARB_ROUND_ROBIN_EN
    // Remember the most recent winner for the next conflict.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
        end else if (w_push) begin
            r_last_grant <= w_gnt1;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end
`endif

    // Head entry is forced to zero while reset is asserted.
    always_comb begin
        if (reset_n) begin
            rsp_id   = r_mem[r_rd_ptr][32];
            rsp_data = r_mem[r_rd_ptr][31:0];
        end else begin
            rsp_id   = 1'b0;
            rsp_data = 32'd0;
        end
    end

    assign rsp_valid = w_rsp_valid;
    assign busy      = w_rsp_valid | req0_valid | req1_valid;
endmodule
